// File: rtl/seq_pattern_comp.sv
// Sliding-window pattern comparator: one-cycle MATCH pulse on each hit plus a saturating hit count.
// Optional macro SPC_MASK_EN adds per-word compare masks (LOAD_MASK port, MASK registers).
module seq_pattern_comp #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   parameter int unsigned CntW  = 8,
   localparam int unsigned IdxW  = $clog2(Depth),
   localparam int unsigned FillW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [IdxW-1:0]  load_idx_i,
   input  logic [Width-1:0] load_data_i,
`ifdef SPC_MASK_EN
   input  logic [Width-1:0] load_mask_i,
`endif
   input  logic             in_valid_i,
   input  logic [Width-1:0] in_data_i,
   input  logic             flush_i,
   input  logic             clr_cnt_i,
   output logic             match_o,
   output logic             armed_o,
   output logic [CntW-1:0]  match_cnt_o
);

   typedef enum logic [1:0] {StEmpty, StFilling, StArmed} state_e;

   state_e           state_q, state_d;
   logic [Width-1:0] win_q  [Depth];
   logic [Width-1:0] win_d  [Depth];
   logic [Width-1:0] pat_q  [Depth];
   logic [Width-1:0] mask_w [Depth];
   logic [FillW-1:0] fill_q, fill_d;
   logic [CntW-1:0]  cnt_q;
   logic             match_q;
   logic             beat;
   logic             hit;

`ifdef SPC_MASK_EN
   logic [Width-1:0] mask_q [Depth];
   assign mask_w = mask_q;
`else
   always_comb begin
      for (int i = 0; i < Depth; i++) mask_w[i] = '1;
   end
`endif

   // A flush in the same cycle drops the incoming beat.
   assign beat = in_valid_i & ~flush_i;

   always_comb begin
      fill_d = fill_q;
      for (int i = 0; i < Depth; i++) win_d[i] = win_q[i];
      if (beat) begin
         for (int i = 0; i < Depth - 1; i++) win_d[i] = win_q[i + 1];
         win_d[Depth-1] = in_data_i;
         if (fill_q != FillW'(Depth)) fill_d = fill_q + 1'b1;
      end
      // Compare the post-shift window against the pattern as it stood before any same-cycle load.
      hit = beat && (fill_d == FillW'(Depth));
      for (int i = 0; i < Depth; i++) begin
         if (((win_d[i] ^ pat_q[i]) & mask_w[i]) != '0) hit = 1'b0;
      end
      if (flush_i)                          state_d = StEmpty;
      else if (fill_d == FillW'(Depth))     state_d = StArmed;
      else if (fill_d == '0)                state_d = StEmpty;
      else                                  state_d = StFilling;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StEmpty;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < Depth; i++) begin
            win_q[i] <= '0;
            pat_q[i] <= '0;
`ifdef SPC_MASK_EN
            mask_q[i] <= '1;
`endif
         end
      end else begin
         state_q <= state_d;
         match_q <= hit;
         if (flush_i) begin
            fill_q <= '0;
            for (int i = 0; i < Depth; i++) win_q[i] <= '0;
         end else if (in_valid_i) begin
            fill_q <= fill_d;
            for (int i = 0; i < Depth; i++) win_q[i] <= win_d[i];
         end
         if (clr_cnt_i) begin
            cnt_q <= '0;
         end else if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (load_i && (32'(load_idx_i) < Depth)) begin
            pat_q[load_idx_i] <= load_data_i;
`ifdef SPC_MASK_EN
            mask_q[load_idx_i] <= load_mask_i;
`endif
         end
      end
   end

   assign match_o     = match_q;
   assign armed_o     = (state_q == StArmed);
   assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_pattern_comp.sv
// Bench for seq_pattern_comp: directed scenarios plus random traffic against a queue-based model.
// Honours SPC_MASK_EN the same way as the design.
module tb_seq_pattern_comp;

   localparam int unsigned W = 8;
   localparam int unsigned D = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load;
   logic [1:0]   load_idx;
   logic [W-1:0] load_data;
   logic [W-1:0] load_mask;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         flush;
   logic         clr_cnt;
   logic         match, armed, match2, armed2;
   logic [7:0]   cnt;
   logic [1:0]   cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] hist [$];
   logic [W-1:0] m_pat  [D];
   logic [W-1:0] m_mask [D];
   int           m_cnt, m_cnt2;
   logic [W-1:0] alpha [4];

   always #5 clk = ~clk;

   seq_pattern_comp #(.Width(W), .Depth(D), .CntW(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .load_i(load), .load_idx_i(load_idx),
      .load_data_i(load_data),
`ifdef SPC_MASK_EN
      .load_mask_i(load_mask),
`endif
      .in_valid_i(in_valid), .in_data_i(in_data), .flush_i(flush), .clr_cnt_i(clr_cnt),
      .match_o(match), .armed_o(armed), .match_cnt_o(cnt)
   );

   seq_pattern_comp #(.Width(W), .Depth(D), .CntW(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .load_i(load), .load_idx_i(load_idx),
      .load_data_i(load_data),
`ifdef SPC_MASK_EN
      .load_mask_i(load_mask),
`endif
      .in_valid_i(in_valid), .in_data_i(in_data), .flush_i(flush), .clr_cnt_i(clr_cnt),
      .match_o(match2), .armed_o(armed2), .match_cnt_o(cnt2)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic pattern_seen();
      for (int i = 0; i < D; i++) begin
         if (((hist[i] ^ m_pat[i]) & m_mask[i]) != '0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Advance the model by one clock using the currently driven inputs, then compare.
   task automatic tick();
      logic hit;
      hit = 1'b0;
      if (!rst_n) begin
         hist.delete();
         for (int i = 0; i < D; i++) begin
            m_pat[i]  = '0;
            m_mask[i] = '1;
         end
         m_cnt  = 0;
         m_cnt2 = 0;
      end else begin
         if (flush) begin
            hist.delete();
         end else if (in_valid) begin
            hist.push_back(in_data);
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) hit = pattern_seen();
         end
         if (clr_cnt) begin
            m_cnt  = 0;
            m_cnt2 = 0;
         end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (load && (int'(load_idx) < D)) begin
            m_pat[load_idx] = load_data;
`ifdef SPC_MASK_EN
            m_mask[load_idx] = load_mask;
`endif
         end
      end
      @(posedge clk);
      #1;
      check_eq("match", {31'd0, match}, {31'd0, hit});
      check_eq("armed", {31'd0, armed}, {31'd0, hist.size() == D});
      check_eq("cnt", {24'd0, cnt}, m_cnt);
      check_eq("match2", {31'd0, match2}, {31'd0, hit});
      check_eq("armed2", {31'd0, armed2}, {31'd0, hist.size() == D});
      check_eq("cnt2", {30'd0, cnt2}, m_cnt2);
   endtask

   task automatic quiet();
      load = 1'b0; in_valid = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
   endtask

   task automatic idle();
      quiet();
      tick();
   endtask

   task automatic beat(input logic [W-1:0] d);
      quiet();
      in_valid = 1'b1;
      in_data  = d;
      tick();
      quiet();
   endtask

   task automatic load_word(input int idx, input logic [W-1:0] d, input logic [W-1:0] m);
      quiet();
      load      = 1'b1;
      load_idx  = 2'(idx);
      load_data = d;
      load_mask = m;
      tick();
      quiet();
   endtask

   task automatic load_pat(input logic [W-1:0] a, b, c, e);
      load_word(0, a, 8'hFF);
      load_word(1, b, 8'hFF);
      load_word(2, c, 8'hFF);
      load_word(3, e, 8'hFF);
   endtask

   task automatic do_flush();
      quiet();
      flush = 1'b1;
      tick();
      quiet();
   endtask

   task automatic do_clr();
      quiet();
      clr_cnt = 1'b1;
      tick();
      quiet();
   endtask

   initial begin
      logic t6_exp;
      alpha[0] = 8'h11; alpha[1] = 8'h22; alpha[2] = 8'h33; alpha[3] = 8'h44;
      load_idx = '0; load_data = '0; load_mask = 8'hFF; in_data = '0;
      quiet();

      // Reset held with random activity on the inputs.
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load = 1'($urandom); load_idx = 2'($urandom); load_data = 8'($urandom);
         in_valid = 1'($urandom); in_data = 8'($urandom); clr_cnt = 1'($urandom);
         tick();
      end
      check_eq("rst_cnt", {24'd0, cnt}, 0);
      rst_n = 1'b1;
      quiet();
      idle();

      // Basic hit with idle gaps.
      load_pat(8'h11, 8'h22, 8'h33, 8'h44);
      beat(8'h11); idle(); beat(8'h22); idle(); idle(); beat(8'h33); beat(8'h44);
      check_eq("t2_match", {31'd0, match}, 1);
      check_eq("t2_cnt", {24'd0, cnt}, 1);
      idle();

      // Overlapping matches on a repeated word.
      do_clr();
      load_pat(8'hAA, 8'hAA, 8'hAA, 8'hAA);
      for (int i = 0; i < 6; i++) beat(8'hAA);
      check_eq("t3_cnt", {24'd0, cnt}, 3);

      // Flush splits a sequence; same-cycle flush drops the beat.
      load_pat(8'h11, 8'h22, 8'h33, 8'h44);
      do_flush();
      beat(8'h11); beat(8'h22); do_flush(); beat(8'h33); beat(8'h44);
      check_eq("t4_armed", {31'd0, armed}, 0);
      beat(8'h11); beat(8'h22); beat(8'h33);
      quiet(); in_valid = 1'b1; in_data = 8'h44; flush = 1'b1; tick(); quiet();
      beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
      check_eq("t4_match", {31'd0, match}, 1);

      // Mid-stream reset discards the partial window.
      beat(8'h11); beat(8'h22);
      rst_n = 1'b0; idle(); rst_n = 1'b1;
      beat(8'h33); beat(8'h44);
      check_eq("rst_mid_match", {31'd0, match}, 0);

      // Saturation of the narrow counter, then clear racing an increment.
      load_pat(8'hAA, 8'hAA, 8'hAA, 8'hAA);
      for (int i = 0; i < 8; i++) beat(8'hAA);
      check_eq("t5_cnt2_sat", {30'd0, cnt2}, 3);
      check_eq("t5_cnt", {24'd0, cnt}, 5);
      quiet(); in_valid = 1'b1; in_data = 8'hAA; clr_cnt = 1'b1; tick(); quiet();
      check_eq("t5_clr_match", {31'd0, match}, 1);
      check_eq("t5_clr_cnt", {24'd0, cnt}, 0);

      // Masked compare on word 2.
      load_pat(8'h11, 8'h22, 8'h03, 8'h44);
      load_word(2, 8'h03, 8'h0F);
      do_flush();
      beat(8'h11); beat(8'h22); beat(8'hF3); beat(8'h44);
`ifdef SPC_MASK_EN
      t6_exp = 1'b1;
`else
      t6_exp = 1'b0;
`endif
      check_eq("t6_match", {31'd0, match}, {31'd0, t6_exp});

      // Random traffic over a small alphabet so hits occur regularly.
      load_pat(8'h11, 8'h22, 8'h33, 8'h44);
      for (int n = 0; n < 3000; n++) begin
         quiet();
         rst_n     = ($urandom_range(199) != 0);
         in_valid  = ($urandom_range(9) < 7);
         in_data   = alpha[$urandom_range(3)];
         flush     = ($urandom_range(29) == 0);
         clr_cnt   = ($urandom_range(49) == 0);
         load      = ($urandom_range(19) == 0);
         load_idx  = 2'($urandom);
         load_data = alpha[$urandom_range(3)];
         load_mask = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
         tick();
      end
      rst_n = 1'b1;
      quiet();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
